// File: rtl/pmem_burst_adapter.sv
`default_nettype none
// pmem_burst_adapter: splits cache line fills and write-backs into BEAT_W-wide
// bursts on the physical-memory side.  Revision 1.0
module pmem_burst_adapter #(
   parameter int LINE_W = 128,
   parameter int BEAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [15:0]       pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [15:0]       mem_address,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic [BEAT_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int          BEATS     = LINE_W / BEAT_W;
   localparam int          CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int          OFF_W     = $clog2(LINE_W / 8);
   localparam logic [15:0] ADDR_MASK = 16'hFFFF << OFF_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [15:0]       r_addr;
   logic [LINE_W-1:0] r_wline;
   logic [LINE_W-1:0] r_fill;
   logic              w_in_burst;
   logic              w_last;
   logic [BEAT_W-1:0] w_wbeat [BEATS];

   assign w_in_burst = (r_state == RD_BURST) || (r_state == WR_BURST);
   assign w_last     = (r_cnt == CNT_W'(BEATS - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            // Write-back wins so a dirty victim is saved before its replacement is fetched.
            if (pmem_write)
               w_next = WR_BURST;
            else if (pmem_read)
               w_next = RD_BURST;
         end
         RD_BURST, WR_BURST: begin
            if (mem_resp && w_last)
               w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wline <= '0;
         r_fill  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE) begin
            if (pmem_write) begin
               r_addr  <= pmem_address & ADDR_MASK;
               r_wline <= pmem_wdata;
               r_cnt   <= '0;
            end else if (pmem_read) begin
               r_addr  <= pmem_address & ADDR_MASK;
               r_cnt   <= '0;
            end
         end
         if (w_in_burst && mem_resp) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == RD_BURST) begin
               for (int k = 0; k < BEATS; k++) begin
                  if (r_cnt == CNT_W'(k))
                     r_fill[k*BEAT_W +: BEAT_W] <= mem_rdata;
               end
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < BEATS; g++) begin : g_wbeat
         assign w_wbeat[g] = r_wline[g*BEAT_W +: BEAT_W];
      end
   endgenerate

   assign mem_wdata   = w_wbeat[r_cnt];
   assign mem_read    = (r_state == RD_BURST);
   assign mem_write   = (r_state == WR_BURST);
   assign mem_address = r_addr;
   assign pmem_resp   = (r_state == DONE);
   assign pmem_rdata  = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_pmem_burst_adapter.sv
`default_nettype none
// Scoreboard bench for pmem_burst_adapter at the default 128/32 geometry.
module tb_pmem_burst_adapter;

   localparam int LINE_W = 128;
   localparam int BEAT_W = 32;
   localparam int BEATS  = LINE_W / BEAT_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              pmem_read = 1'b0;
   logic              pmem_write = 1'b0;
   logic [15:0]       pmem_address = '0;
   logic [LINE_W-1:0] pmem_wdata = '0;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;
   logic              mem_read;
   logic              mem_write;
   logic [15:0]       mem_address;
   logic [BEAT_W-1:0] mem_wdata;
   logic [BEAT_W-1:0] mem_rdata = '0;
   logic              mem_resp = 1'b0;

   pmem_burst_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp)
   );

   always #5 clk = ~clk;

   int                n_checks = 0;
   int                n_fail   = 0;
   logic [LINE_W-1:0] exp_rline [$];
   logic [BEAT_W-1:0] exp_wbeat [$];
   logic [LINE_W-1:0] last_fill = '0;

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Call at a negedge where the DUT is idle and the request is already driven;
   // returns at the negedge where pmem_resp is high.
   task automatic run_burst(input string tag, input bit is_rd, input logic [15:0] addr,
                            input logic [LINE_W-1:0] line, input int stall_beat,
                            input int stall_n, input int exp_lat);
      int                k        = 0;
      int                stalls   = 0;
      bit                done     = 1'b0;
      logic [15:0]       exp_addr = addr & 16'hFFF0;
      logic [LINE_W-1:0] saved_wd = pmem_wdata;
      if (is_rd)
         exp_rline.push_back(line);
      else
         for (int b = 0; b < BEATS; b++) exp_wbeat.push_back(line[b*BEAT_W +: BEAT_W]);
      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            // Scramble the request side; the burst must run on captured values.
            pmem_address = ~addr;
            pmem_wdata   = ~saved_wd;
         end
         if (pmem_resp) begin
            done = 1'b1;
            chk({tag, " latency"}, LINE_W'(cyc), LINE_W'(exp_lat));
            chk({tag, " beats"}, LINE_W'(k), LINE_W'(BEATS));
            if (is_rd) begin
               chk({tag, " rdata"}, pmem_rdata, exp_rline.pop_front());
               last_fill = line;
            end else begin
               chk({tag, " rdata kept"}, pmem_rdata, last_fill);
            end
            mem_resp     = 1'b0;
            pmem_address = addr;
            pmem_wdata   = saved_wd;
         end else begin
            chk({tag, " strobes"}, LINE_W'({mem_read, mem_write}), LINE_W'(is_rd ? 2'b10 : 2'b01));
            chk({tag, " addr"}, LINE_W'(mem_address), LINE_W'(exp_addr));
            if (!is_rd) begin
               if (exp_wbeat.size() == 0) chk({tag, " extra beat"}, LINE_W'(k), LINE_W'(BEATS));
               else chk({tag, " wdata"}, LINE_W'(mem_wdata), LINE_W'(exp_wbeat[0]));
            end
            if (k == stall_beat && stalls < stall_n) begin
               mem_resp = 1'b0;
               stalls++;
            end else begin
               mem_resp = 1'b1;
               if (is_rd) mem_rdata = line[k*BEAT_W +: BEAT_W];
               else if (exp_wbeat.size() != 0) void'(exp_wbeat.pop_front());
               k++;
            end
         end
      end
      if (!done) chk({tag, " timeout"}, LINE_W'(0), LINE_W'(1));
   endtask

   task automatic idle_after(input string tag);
      @(negedge clk);
      chk({tag, " resp width"}, LINE_W'(pmem_resp), LINE_W'(0));
      chk({tag, " idle strobes"}, LINE_W'({mem_read, mem_write}), LINE_W'(0));
      chk({tag, " fill held"}, pmem_rdata, last_fill);
   endtask

   initial begin
      // Reset state, with requests and acks wiggling to show they are ignored.
      pmem_read = 1'b1; pmem_write = 1'b1; mem_resp = 1'b1;
      pmem_address = 16'hBEEF; pmem_wdata = {4{32'hFFFF_FFFF}};
      repeat (2) @(negedge clk);
      chk("rst resp", LINE_W'(pmem_resp), LINE_W'(0));
      chk("rst strobes", LINE_W'({mem_read, mem_write}), LINE_W'(0));
      chk("rst rdata", pmem_rdata, '0);
      chk("rst addr", LINE_W'(mem_address), LINE_W'(0));
      chk("rst wdata", LINE_W'(mem_wdata), LINE_W'(0));
      pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("post rst strobes", LINE_W'({mem_read, mem_write, pmem_resp}), LINE_W'(0));

      // Plain read with ack held high.
      pmem_address = 16'h1236; pmem_read = 1'b1;
      run_burst("rd basic", 1'b1, 16'h1236,
                128'h44444444_33333333_22222222_11111111, -1, 0, 5);
      pmem_read = 1'b0;
      idle_after("rd basic");

      // Write-back: beats leave LSB first, fill register untouched.
      pmem_address = 16'h2A5F; pmem_wdata = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
      pmem_write = 1'b1;
      run_burst("wr basic", 1'b0, 16'h2A5F, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, -1, 0, 5);
      pmem_write = 1'b0;
      idle_after("wr basic");

      // Read stalled 3 cycles before beat 2.
      pmem_address = 16'h0FFF; pmem_read = 1'b1;
      run_burst("rd stall", 1'b1, 16'h0FFF,
                128'hA5A5A5A5_0BADF00D_DEADBEEF_CAFEF00D, 2, 3, 8);
      pmem_read = 1'b0;
      idle_after("rd stall");

      // Read and write together: write-back first (with a stall), then the fill.
      pmem_address = 16'h8004; pmem_wdata = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      pmem_read = 1'b1; pmem_write = 1'b1;
      run_burst("both wr", 1'b0, 16'h8004, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 2, 7);
      pmem_write = 1'b0;
      idle_after("both wr");
      run_burst("both rd", 1'b1, 16'h8004,
                128'h5555AAAA_6666BBBB_7777CCCC_8888DDDD, -1, 0, 5);
      pmem_read = 1'b0;
      idle_after("both rd");

      // Reset after beat 1 of a read aborts it.
      pmem_address = 16'h4440; pmem_read = 1'b1;
      @(negedge clk);
      chk("abort rd strobe", LINE_W'(mem_read), LINE_W'(1));
      mem_resp = 1'b1; mem_rdata = 32'h1111_0000;
      @(negedge clk);
      mem_rdata = 32'h2222_0001;
      @(negedge clk);
      reset = 1'b1;
      #1;
      last_fill = '0;
      chk("abort mem_read", LINE_W'(mem_read), LINE_W'(0));
      chk("abort resp", LINE_W'(pmem_resp), LINE_W'(0));
      chk("abort rdata", pmem_rdata, '0);
      chk("abort addr", LINE_W'(mem_address), LINE_W'(0));
      pmem_read = 1'b0; mem_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort no resp", LINE_W'(pmem_resp), LINE_W'(0));
      end
      reset = 1'b0;
      @(negedge clk);
      pmem_address = 16'h4448; pmem_read = 1'b1;
      run_burst("rd after abort", 1'b1, 16'h4448,
                128'h0000000D_0000000C_0000000B_0000000A, -1, 0, 5);
      pmem_read = 1'b0;
      idle_after("rd after abort");

      // Acks while idle must not advance the beat counter.
      mem_resp = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle ack resp", LINE_W'(pmem_resp), LINE_W'(0));
      chk("idle ack strobes", LINE_W'({mem_read, mem_write}), LINE_W'(0));
      pmem_address = 16'h7777; pmem_read = 1'b1;
      run_burst("rd idle ack", 1'b1, 16'h7777,
                128'hF0F0F0F0_E1E1E1E1_D2D2D2D2_C3C3C3C3, -1, 0, 5);
      pmem_read = 1'b0;
      idle_after("rd idle ack");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
